sinc_filter: RTL and testbench
==============================

// Module: sinc_filter
// PURPOSE
//  Programmable sinc1/sinc2/sinc3 decimation filter for one sigma-delta modulator channel.
//  Integrators run at the modulator bit rate; combs run at the decimated rate set by the
//  osr_signal strobe from the decimation control unit.
//  Produces an unsigned, shifted, saturated sample with a ready/ack handshake toward the
//  register/FIFO layer.
// PARAMETERS
//  ACC_W  32  integrator/comb width; must be >= 3*log2(OSR_max)+1 (25 for OSR 256)
//  OUT_W  16  output sample width
// PORTS
//  clk_in      in   1      single clock, all logic on rising edge
//  SYSRST      in   1      reset, synchronous, active-high
//  en          in   1      filter enable; 0 synchronously clears filter state
//  ce          in   1      modulator bit strobe; bit_in is valid when ce=1
//  bit_in      in   1      modulator bit (0 or 1, accumulated as 0/1)
//  osr_signal  in   1      decimation strobe from the decimation control unit; used only when ce=1
//  order       in   2      0=sinc1, 1=sinc2, 2=sinc3, 3=sinc3
//  shift       in   5      right shift applied to the raw comb result
//  data_ack    in   1      one-cycle pulse: consumer has read data_out
//  data_out    out  OUT_W  filtered sample
//  data_ready  out  1      sample available, held until acknowledged
//  overrun     out  1      sticky: a new sample was written while data_ready=1
// BEHAVIOUR
//  Reset (SYSRST=1)
//   - All integrators, comb delays, settle counter, data_out, data_ready and overrun go to 0.
//  Disable (en=0)
//   - Same clear, except data_out holds its value. Takes priority over ce and data_ack.
//  Integrators (update when en & ce)
//   - i1<=i1+bit_in; i2<=i2+i1; i3<=i3+i2.
//   - Each update uses the pre-edge values.
//   - Arithmetic is modulo 2^ACC_W; wrap is legal because the combs recover it.
//  Tap selection
//   - tap = i1/i2/i3 per order.
//   - Tap is taken after this cycle's integrator update; the decimating sample includes
//     the current bit.
//  Combs (update when en & ce & osr_signal, the decimation event)
//   - c1 = tap - d1; c2 = c1 - d2; c3 = c2 - d3.
//   - d1<=tap, d2<=c1, d3<=c2.
//   - Combinational within the cycle; raw = c1/c2/c3 per order.
//  Output stage
//   - res = raw >> shift (logical).
//   - If res > 2^OUT_W-1, output 2^OUT_W-1 (saturation).
//  Settling
//   - A 2-bit counter suppresses the first (order+1) decimation events after reset or
//     en rising (sinc1: 1, sinc2: 2, sinc3: 3, order=3 treated as 3).
//   - Suppressed events update the comb delays only.
//   - The counter saturates; a later change of order does not restart it.
//  Output latency
//   - On an unsuppressed decimation event, data_out and data_ready=1 are registered at
//     that edge.
//   - Both are visible the cycle after the event.
//  Handshake
//   - data_ack clears data_ready.
//   - If data_ack and a new sample occur on the same edge, the new sample wins:
//     data_ready stays 1, overrun is not set.
//   - If a new sample arrives while data_ready=1 and there is no ack, overrun<=1 and
//     data_out is overwritten.
//   - overrun clears only on SYSRST or en=0.
//   - data_ack while data_ready=0 is ignored.
//  Corner cases
//   - osr_signal while ce=0 is ignored.
//   - An order or shift change mid-run takes effect at the next event; software
//     re-enables to resettle.
// STRUCTURE
//  Package sdfm_pkg
//   - ORDER_SINC1/2/3 encodings, default ACC_W/OUT_W, saturation helper function.
//  Sub-module sinc_comb_stage
//   - Delay register + subtractor, instantiated 3x.
//  Integrators, settle counter and handshake stay inline.
// TESTING
//  1. SYSRST=1 for 2 cycles -> data_out=0, data_ready=0, overrun=0.
//  2. sinc1, bit_in=1, ce=1 every cycle, OSR 16 (value_dec=15), shift=0
//     -> first event suppressed, then data_out=16 every 16 cycles.
//  3. sinc3, all ones, OSR 16, shift=4
//     -> 3 events suppressed, then data_out=256 (4096>>4) steady.
//  4. sinc3, all ones, OSR 256, shift=0, OUT_W=16 -> raw 16777216, data_out=65535 (saturated).
//  5. sinc2, bit_in=1010..., OSR 16, shift=0 -> data_out=128 steady after settling.
//  6. Handshake:
//     - no data_ack across 2 samples -> overrun=1, data_out=latest.
//     - ack coincident with new sample -> data_ready stays 1, overrun stays 0.
//  7. en=0 mid-run for 1 cycle, then en=1 -> data_ready=0, overrun=0, data_out held;
//     settling restarts.

Source files
------------

// File: rtl/sdfm_pkg.sv
// -----------------------------------------------------------------------------
// sdfm_pkg
// Shared definitions for the sigma-delta filter channel:
//   - filter order encodings
//   - default integrator/comb and output widths
//   - helper functions: saturation detection and settling event count
// -----------------------------------------------------------------------------
package sdfm_pkg;

    localparam int ACC_W_DEF = 32;
    localparam int OUT_W_DEF = 16;

    typedef enum logic [1:0] {
        ORDER_SINC1  = 2'd0,
        ORDER_SINC2  = 2'd1,
        ORDER_SINC3  = 2'd2,
        ORDER_SINC3B = 2'd3   // alias, behaves as sinc3
    } order_e;

    // True when val does not fit in out_w unsigned bits, i.e. the output
    // must be clamped to all ones. Values are passed zero-extended to 64 bits,
    // so ACC_W must stay below 64.
    function automatic logic sat_overflow(input logic [63:0] val, input int unsigned out_w);
        return ((val >> out_w) != 64'd0);
    endfunction

    // Number of decimation events whose comb output is not yet valid:
    // one per comb stage in use.
    function automatic logic [1:0] settle_events(input logic [1:0] ord);
        logic [1:0] n;
        case (ord)
            ORDER_SINC1: n = 2'd1;
            ORDER_SINC2: n = 2'd2;
            ORDER_SINC3: n = 2'd3;
            default:     n = 2'd3;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sinc_comb_stage.sv
// -----------------------------------------------------------------------------
// sinc_comb_stage
// One comb section of the decimator: y = x - delay, and on each decimation
// event the delay register captures x.
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset
//   i_en    filter enable, 0 clears the delay register
//   i_load  decimation event, delay <= x
//   i_x     stage input
//   o_y     stage output (combinational difference)
// -----------------------------------------------------------------------------
module sinc_comb_stage #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_y
);

    logic [W-1:0] r_delay;

    // Delay register: cleared on reset/disable, loaded on decimation events.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_delay <= '0;
        end else if (!i_en) begin
            r_delay <= '0;
        end else if (i_load) begin
            r_delay <= i_x;
        end else begin
            r_delay <= r_delay;
        end
    end

    // Modulo subtraction recovers the integrator wrap-around.
    assign o_y = i_x - r_delay;

endmodule

// File: rtl/sinc_filter.sv
// -----------------------------------------------------------------------------
// sinc_filter
// Programmable sinc1/sinc2/sinc3 decimation filter for one sigma-delta channel.
// Integrators run on every modulator bit strobe (ce), combs on decimation
// events (ce & osr_signal). Output is shifted, saturated and offered with a
// ready/ack handshake.
// Ports:
//   clk_in      clock, all logic on rising edge
//   SYSRST      synchronous active-high reset
//   en          enable; 0 clears filter state (data_out holds)
//   ce          modulator bit strobe
//   bit_in      modulator bit
//   osr_signal  decimation strobe, qualified by ce
//   order       0=sinc1, 1=sinc2, 2/3=sinc3
//   shift       logical right shift of the raw comb result
//   data_ack    consumer read pulse, clears data_ready
//   data_out    filtered sample (registered)
//   data_ready  sample pending until acknowledged
//   overrun     sticky: sample overwritten while still pending
// -----------------------------------------------------------------------------
module sinc_filter
    import sdfm_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk_in,
    input  logic             SYSRST,
    input  logic             en,
    input  logic             ce,
    input  logic             bit_in,
    input  logic             osr_signal,
    input  logic [1:0]       order,
    input  logic [4:0]       shift,
    input  logic             data_ack,
    output logic [OUT_W-1:0] data_out,
    output logic             data_ready,
    output logic             overrun
);

    logic [ACC_W-1:0] r_i1, r_i2, r_i3;
    logic [ACC_W-1:0] w_i1_nxt, w_i2_nxt, w_i3_nxt;
    logic [ACC_W-1:0] w_tap, w_c1, w_c2, w_c3, w_raw, w_res;
    logic [1:0]       r_settle;
    logic             w_event, w_new_sample, w_sat;
    logic [OUT_W-1:0] w_sample;
    logic [OUT_W-1:0] r_data_out;
    logic             r_data_ready, r_overrun;

    assign w_event = en & ce & osr_signal;

    // Each integrator adds the pre-edge value of the previous stage.
    assign w_i1_nxt = r_i1 + {{(ACC_W-1){1'b0}}, bit_in};
    assign w_i2_nxt = r_i2 + r_i1;
    assign w_i3_nxt = r_i3 + r_i2;

    // Integrator chain, advancing once per modulator bit.
    always_ff @(posedge clk_in) begin
        if (SYSRST || !en) begin
            r_i1 <= '0;
            r_i2 <= '0;
            r_i3 <= '0;
        end else if (ce) begin
            r_i1 <= w_i1_nxt;
            r_i2 <= w_i2_nxt;
            r_i3 <= w_i3_nxt;
        end else begin
            r_i1 <= r_i1;
            r_i2 <= r_i2;
            r_i3 <= r_i3;
        end
    end

    // Tap uses the post-update integrator so the decimating sample includes
    // the current bit.
    always_comb begin
        w_tap = w_i3_nxt;
        case (order)
            ORDER_SINC1: w_tap = w_i1_nxt;
            ORDER_SINC2: w_tap = w_i2_nxt;
            ORDER_SINC3: w_tap = w_i3_nxt;
            default:     w_tap = w_i3_nxt;
        endcase
    end

    // All three stages always load, so the unused ones stay harmless.
    sinc_comb_stage #(.W(ACC_W)) u_comb1 (
        .i_clk (clk_in), .i_rst (SYSRST), .i_en (en), .i_load (w_event),
        .i_x   (w_tap),  .o_y   (w_c1)
    );
    sinc_comb_stage #(.W(ACC_W)) u_comb2 (
        .i_clk (clk_in), .i_rst (SYSRST), .i_en (en), .i_load (w_event),
        .i_x   (w_c1),   .o_y   (w_c2)
    );
    sinc_comb_stage #(.W(ACC_W)) u_comb3 (
        .i_clk (clk_in), .i_rst (SYSRST), .i_en (en), .i_load (w_event),
        .i_x   (w_c2),   .o_y   (w_c3)
    );

    // Raw comb result selection by filter order.
    always_comb begin
        w_raw = w_c3;
        case (order)
            ORDER_SINC1: w_raw = w_c1;
            ORDER_SINC2: w_raw = w_c2;
            ORDER_SINC3: w_raw = w_c3;
            default:     w_raw = w_c3;
        endcase
    end

    assign w_res    = w_raw >> shift;
    assign w_sat    = sat_overflow({{(64-ACC_W){1'b0}}, w_res}, OUT_W);
    assign w_sample = w_sat ? {OUT_W{1'b1}} : w_res[OUT_W-1:0];

    // Settle counter: saturating count of decimation events since restart.
    always_ff @(posedge clk_in) begin
        if (SYSRST || !en) begin
            r_settle <= 2'd0;
        end else if (w_event && (r_settle != 2'd3)) begin
            r_settle <= r_settle + 2'd1;
        end else begin
            r_settle <= r_settle;
        end
    end

    assign w_new_sample = w_event && (r_settle >= settle_events(order));

    // Output register and handshake; a new sample beats a coincident ack.
    always_ff @(posedge clk_in) begin
        if (SYSRST) begin
            r_data_out   <= '0;
            r_data_ready <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (!en) begin
            r_data_out   <= r_data_out;
            r_data_ready <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_new_sample) begin
            r_data_out   <= w_sample;
            r_data_ready <= 1'b1;
            r_overrun    <= r_overrun | (r_data_ready & ~data_ack);
        end else if (data_ack) begin
            r_data_out   <= r_data_out;
            r_data_ready <= 1'b0;
            r_overrun    <= r_overrun;
        end else begin
            r_data_out   <= r_data_out;
            r_data_ready <= r_data_ready;
            r_overrun    <= r_overrun;
        end
    end

    assign data_out   = r_data_out;
    assign data_ready = r_data_ready;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_sinc_filter.sv
// -----------------------------------------------------------------------------
// tb_sinc_filter
// Bench for sinc_filter. The reference computes cascaded moving sums of the
// bit history (direct FIR form); expected samples are queued when a
// decimation event is driven and popped when the output is due.
// -----------------------------------------------------------------------------
module tb_sinc_filter;

    logic        clk_in = 1'b0;
    logic        SYSRST, en, ce, bit_in, osr_signal, data_ack;
    logic [1:0]  order;
    logic [4:0]  shift;
    logic [15:0] data_out;
    logic        data_ready, overrun;

    sinc_filter dut (
        .clk_in     (clk_in),
        .SYSRST     (SYSRST),
        .en         (en),
        .ce         (ce),
        .bit_in     (bit_in),
        .osr_signal (osr_signal),
        .order      (order),
        .shift      (shift),
        .data_ack   (data_ack),
        .data_out   (data_out),
        .data_ready (data_ready),
        .overrun    (overrun)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int ord;
        int osr;
        int shf;
        bit alt;   // 1010... pattern instead of all ones
        bit gap;   // ce only every other cycle, osr_signal noise when ce=0
        int nev;   // decimation events to run
        int expv;  // steady output value
    } vec_t;

    vec_t tbl[10];

    int     checks = 0;
    int     failures = 0;
    longint xh [0:4095];
    longint y1h[0:4095];
    longint y2h[0:4095];
    longint y3h[0:4095];
    int     n, ev_cnt, R, n_out;
    longint q[$];
    logic   ready_m, ovr_m;
    longint out_m;
    longint case_exp;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic longint gx(input int i);  return (i < 0) ? 0 : xh[i];  endfunction
    function automatic longint gy1(input int i); return (i < 0) ? 0 : y1h[i]; endfunction
    function automatic longint gy2(input int i); return (i < 0) ? 0 : y2h[i]; endfunction
    function automatic longint gy3(input int i); return (i < 0) ? 0 : y3h[i]; endfunction

    function automatic int tgt_of(input logic [1:0] o);
        return (o == 2'd0) ? 1 : (o == 2'd1) ? 2 : 3;
    endfunction

    // One clock: drive inputs, update the reference, then compare outputs.
    task automatic step(input logic b, input logic c, input logic osr,
                        input logic ack, input logic e);
        logic   pushed;
        longint bv, yv, res;
        bit_in = b; ce = c; osr_signal = osr; data_ack = ack; en = e;
        pushed = 1'b0;
        bv = b ? 1 : 0;
        if (!e) begin
            n = 0; ev_cnt = 0; ready_m = 1'b0; ovr_m = 1'b0;
        end else begin
            if (c) begin
                xh[n]  = bv;
                y1h[n] = gy1(n-1) + bv     - gx(n-R);
                y2h[n] = gy2(n-1) + y1h[n] - gy1(n-R);
                y3h[n] = gy3(n-1) + y2h[n] - gy2(n-R);
                if (osr) begin
                    if (ev_cnt >= tgt_of(order)) begin
                        yv  = (order == 2'd0) ? y1h[n] : (order == 2'd1) ? y2h[n] : y3h[n];
                        res = yv >> shift;
                        if (res > 65535) res = 65535;
                        q.push_back(res);
                        pushed = 1'b1;
                    end
                    if (ev_cnt < 3) ev_cnt++;
                end
                n++;
            end
            if (pushed) begin
                if (ready_m && !ack) ovr_m = 1'b1;
                ready_m = 1'b1;
            end else if (ack) begin
                ready_m = 1'b0;
            end
        end
        @(posedge clk_in); #1;
        if (pushed) begin
            out_m = q.pop_front();
            n_out++;
            if (case_exp >= 0) chk("table_value", longint'(data_out), case_exp);
        end
        chk("data_out", longint'(data_out), out_m);
        chk("data_ready", longint'(data_ready), longint'(ready_m));
        chk("overrun", longint'(overrun), longint'(ovr_m));
    endtask

    // One OSR-4 sinc1 segment; the event is on the last bit.
    task automatic seg4(input logic [3:0] bits, input logic ack_last);
        for (int i = 0; i < 4; i++)
            step(bits[i], 1'b1, (i == 3), (i == 3) ? ack_last : 1'b0, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          ord osr shf alt gap nev expv
        tbl[0] = '{0, 16,  0, 0, 0, 4, 16};
        tbl[1] = '{2, 16,  4, 0, 0, 6, 256};
        tbl[2] = '{2, 256, 0, 0, 0, 5, 65535};
        tbl[3] = '{1, 16,  0, 1, 0, 5, 128};
        tbl[4] = '{0, 16,  0, 1, 0, 4, 8};
        tbl[5] = '{3, 16,  4, 0, 0, 5, 256};
        tbl[6] = '{1, 8,   2, 0, 0, 5, 16};
        tbl[7] = '{2, 16,  0, 0, 0, 5, 4096};
        tbl[8] = '{1, 32,  0, 0, 0, 4, 1024};
        tbl[9] = '{1, 16,  0, 0, 1, 5, 256};

        n = 0; ev_cnt = 0; R = 16; n_out = 0;
        ready_m = 1'b0; ovr_m = 1'b0; out_m = 0; case_exp = -1;

        // Reset state
        SYSRST = 1'b1; en = 1'b0; ce = 1'b0; bit_in = 1'b0; osr_signal = 1'b0;
        data_ack = 1'b0; order = 2'd0; shift = 5'd0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_data_out", longint'(data_out), 0);
        chk("rst_data_ready", longint'(data_ready), 0);
        chk("rst_overrun", longint'(overrun), 0);
        SYSRST = 1'b0;

        // Table-driven runs with automatic acknowledge
        for (int t = 0; t < 10; t++) begin
            order    = tbl[t].ord[1:0];
            shift    = tbl[t].shf[4:0];
            R        = tbl[t].osr;
            case_exp = tbl[t].expv;
            n_out    = 0;
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < tbl[t].nev * R; k++) begin
                step(tbl[t].alt ? ((k % 2) == 0) : 1'b1, 1'b1, ((k % R) == R - 1), ready_m, 1'b1);
                if (tbl[t].gap) step(1'b0, 1'b0, 1'b1, ready_m, 1'b1);
            end
            chk("sample_count", n_out, tbl[t].nev - tgt_of(order));
        end
        case_exp = -1;

        // Handshake: overrun, disable, coincident ack
        order = 2'd0; shift = 5'd0; R = 4;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        seg4(4'b1111, 1'b0);                  // suppressed
        chk("hs_first_suppressed", longint'(data_ready), 0);
        seg4(4'b1111, 1'b0);                  // sample 4
        seg4(4'b1001, 1'b0);                  // sample 2, not acked
        chk("hs_overrun", longint'(overrun), 1);
        chk("hs_latest", longint'(data_out), 2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);   // en low for one cycle
        chk("dis_ready", longint'(data_ready), 0);
        chk("dis_overrun", longint'(overrun), 0);
        chk("dis_hold", longint'(data_out), 2);
        seg4(4'b1111, 1'b0);                  // settling restarted
        chk("resettle_suppressed", longint'(data_ready), 0);
        chk("resettle_hold", longint'(data_out), 2);
        seg4(4'b1111, 1'b0);
        chk("resettle_sample", longint'(data_out), 4);
        seg4(4'b0111, 1'b1);                  // ack on the event edge
        chk("coinc_ready", longint'(data_ready), 1);
        chk("coinc_overrun", longint'(overrun), 0);
        chk("coinc_value", longint'(data_out), 3);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("ack_clears", longint'(data_ready), 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);   // ack with nothing pending
        chk("idle_ack_ready", longint'(data_ready), 0);
        chk("idle_ack_overrun", longint'(overrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
